proc_out_buf: RTL and testbench
===============================

# proc_out_buf

Per-channel output buffer sitting directly downstream of the fixed-point processor wrapper. It captures the processor's 32-bit `io_out` word whenever the processor pulses the matching bit of its one-hot `out_en` bus. Each output channel has its own FIFO, presented to downstream consumers through a valid/ready handshake, so a slow consumer cannot lose processor output until its FIFO fills.

## Interface
- `NUBITS`, 32, data word width; matches the processor data width.
- `NUIOOU`, 2, number of output channels; matches the processor `out_en` width.
- `DEPTH`, 8, entries per channel FIFO; must be a power of two and at least 2.
- `LW`, derived as $clog2(DEPTH)+1; level-counter width, not overridable.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `io_out`  in  NUBITS  signed processor output word; valid only in cycles where some `out_en` bit is high.
- `out_en`  in  NUIOOU  one-hot write strobe; bit k writes `io_out` into channel k.
- `m_data`  out  NUIOOU*NUBITS  head word of each channel; channel k occupies bits [k*NUBITS +: NUBITS].
- `m_valid`  out  NUIOOU  channel k has data at its head.
- `m_ready`  in  NUIOOU  consumer k accepts the head word.
- `full`  out  NUIOOU  channel k holds DEPTH entries.
- `level`  out  NUIOOU*LW  occupancy of channel k, in the range 0..DEPTH.
- `ovf`  out  NUIOOU  sticky flag: a write to channel k was dropped.

## Operation
- Channels are fully independent; the rules below apply per channel k.
- **Push:** occurs when `out_en[k]`=1 and either `full[k]`=0 or a pop happens in the same cycle. `io_out` is written at the write pointer, and the pointer increments mod DEPTH (natural wrap).
- **Pop:** occurs when `m_valid[k]`=1 and `m_ready[k]`=1. The read pointer increments mod DEPTH.
- **Level update:**
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- **Dropped write:** if `out_en[k]`=1 and `full[k]`=1 with no pop that cycle, the word is discarded and `ovf[k]` is set. `ovf[k]` stays high until reset.
- **Empty channel:** `m_ready[k]` while `m_valid[k]`=0 has no effect.
- **Multiple `out_en` bits:** the processor never asserts more than one, but if several are high, each flagged channel pushes the same word independently. No error is raised.
- **Empty-channel push and pop:** a push into an empty channel cannot be popped in the same cycle, because `m_valid` is still 0.
- **Output data:** `m_data` is first-word-fall-through and forced to 0 whenever `m_valid[k]`=0.
- **Status outputs:** `m_valid[k]` = (`level[k]` != 0); `full[k]` = (`level[k]` == DEPTH).
- **Storage:** FIFO memory is not reset. Only pointers, levels and `ovf` are reset.

## Timing
- **Reset:** asserting `rst` low immediately clears all pointers, levels and `ovf` without waiting for a clock edge. Consequently `m_valid`, `full`, `level`, `ovf` and `m_data` are all 0 during reset. Reset mid-stream discards all buffered words.
- **Push latency:** a word pushed at rising edge N is visible on `m_data` with `m_valid`=1 in the cycle following edge N.
- **Pop:** takes effect at the edge where valid & ready are both high. The next head, or `m_valid`=0, appears in the following cycle.
- **Throughput:** one push and one pop per channel per cycle, sustained indefinitely with no bubbles.
- **Handshake rule:** `m_valid` never depends combinationally on `m_ready`.
- **Combinational paths:** none from inputs to outputs. The only combinational logic is `m_data`/`m_valid` gating from registered state.

## Structure
- One sub-module, `sync_fifo`, parameterised on width and depth. It provides push, pop, data in, data out, level, full, empty and overflow-on-drop. It is instantiated NUIOOU times in a generate loop.
- The top level only slices `io_out`/`out_en` into channels and concatenates channel outputs onto the flat buses.
- Shared package: the `NUBITS` default, the depth default, and a `clog2`-based level-width helper, reused by the matching input-side buffer.

## Test plan
- **Reset:** hold `rst`=0 mid-stream with channel 0 holding 3 words → all outputs read 0 immediately; after release, `level`=0 and `m_valid`=0.
- **Single write:** pulse `out_en`=2'b01 with `io_out`=32'hFFFF_FFF6 (−10), `m_ready`=0 → next cycle `m_valid`=2'b01, channel 0 `m_data`=32'hFFFF_FFF6, `level[0]`=1; channel 1 untouched.
- **Ordering and wrap:** write 1..12 to channel 1 while popping every other cycle → the consumer receives 1..12 in order across pointer wrap; `ovf[1]`=0.
- **Overflow:** write 9 words to channel 0 with `m_ready`=0 → `full[0]`=1 after the 8th; the 9th is dropped and `ovf[0]`=1. Draining yields words 1..8 only, and `ovf[0]` remains 1.
- **Full with simultaneous pop:** with channel 0 full, assert `out_en[0]` and `m_ready[0]` in the same cycle → the push is accepted, `level` stays 8, `ovf` stays 0, and the new word is the 8th read thereafter.
- **Concurrent channels:** run both channels concurrently, with channel 0 popping at full rate and channel 1 holding `m_ready`=0 → each channel's level and data are independent; after 4 writes to each, `level` reads 0 and 4.

Source files
------------

// File: rtl/proc_out_buf_pkg.sv
// rtl/proc_out_buf_pkg.sv - shared defaults and level-width helper for processor I/O buffers
package proc_out_buf_pkg;

  localparam int NUBITS_DEF = 32;
  localparam int DEPTH_DEF  = 8;

  // Level counters must hold 0..depth inclusive, hence one bit beyond the pointer width.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/proc_out_buf_if.sv
// rtl/proc_out_buf_if.sv - processor write side and per-channel consumer handshake bundle
interface proc_out_buf_if
  import proc_out_buf_pkg::*;
#(
  parameter int NUBITS = NUBITS_DEF,
  parameter int NUIOOU = 2,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int LW = level_width(DEPTH);

  logic signed [NUBITS-1:0]        io_out;
  logic        [NUIOOU-1:0]        out_en;
  logic        [NUIOOU*NUBITS-1:0] m_data;
  logic        [NUIOOU-1:0]        m_valid;
  logic        [NUIOOU-1:0]        m_ready;
  logic        [NUIOOU-1:0]        full;
  logic        [NUIOOU*LW-1:0]     level;
  logic        [NUIOOU-1:0]        ovf;

  // master: processor plus downstream consumers; slave: the buffer itself
  modport master (
    output io_out, out_en, m_ready,
    input  m_data, m_valid, full, level, ovf
  );

  modport slave (
    input  io_out, out_en, m_ready,
    output m_data, m_valid, full, level, ovf
  );

endinterface

// File: rtl/proc_out_buf_sync_fifo.sv
// rtl/proc_out_buf_sync_fifo.sv - single-clock FWFT FIFO with level count and sticky drop flag
module sync_fifo
  import proc_out_buf_pkg::*;
#(
  parameter  int WIDTH = NUBITS_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int LW    = level_width(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_req,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             push, pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  assign ovf   = ovf_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop      = rd_req & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push     = wr_req & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (wr_req && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/proc_out_buf.sv
// rtl/proc_out_buf.sv - per-channel output FIFOs capturing processor io_out on one-hot out_en
module proc_out_buf
  import proc_out_buf_pkg::*;
#(
  parameter int NUBITS = NUBITS_DEF,
  parameter int NUIOOU = 2,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  proc_out_buf_if.slave bus
);

  localparam int LW = level_width(DEPTH);

  logic [NUIOOU-1:0] empty;

  assign bus.m_valid = ~empty;

  for (genvar k = 0; k < NUIOOU; k++) begin : g_ch
    sync_fifo #(
      .WIDTH (NUBITS),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst),
      .wr_req (bus.out_en[k]),
      .din    (bus.io_out),
      .rd_req (bus.m_ready[k]),
      .dout   (bus.m_data[k*NUBITS +: NUBITS]),
      .level  (bus.level[k*LW +: LW]),
      .full   (bus.full[k]),
      .empty  (empty[k]),
      .ovf    (bus.ovf[k])
    );
  end

endmodule

// File: tb/tb_proc_out_buf.sv
// tb/tb_proc_out_buf.sv - scoreboard bench for proc_out_buf
module tb_proc_out_buf;

  localparam int NUBITS = 32;
  localparam int NUIOOU = 2;
  localparam int DEPTH  = 8;
  localparam int LW     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proc_out_buf_if #(.NUBITS(NUBITS), .NUIOOU(NUIOOU), .DEPTH(DEPTH)) bus ();

  proc_out_buf #(.NUBITS(NUBITS), .NUIOOU(NUIOOU), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] mon_e;
  logic        mon_have;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] lvl(input int k);
    return bus.level[k*LW +: LW];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < NUIOOU; k++) begin
      if (rst && bus.m_valid[k] && bus.m_ready[k]) begin
        mon_have = 1'b0;
        if (k == 0 && exp_q0.size() > 0) begin mon_e = exp_q0.pop_front(); mon_have = 1'b1; end
        if (k == 1 && exp_q1.size() > 0) begin mon_e = exp_q1.pop_front(); mon_have = 1'b1; end
        if (!mon_have) chk($sformatf("ch%0d_unexpected_pop", k), 64'd1, 64'd0);
        else chk($sformatf("ch%0d_pop_data", k), 64'(bus.m_data[k*NUBITS +: NUBITS]), 64'(mon_e));
      end
    end
  end

  task automatic cyc(input logic [1:0] en, input logic [31:0] d, input logic [1:0] rdy, input logic [1:0] acc);
    bus.out_en  = en;
    bus.io_out  = d;
    bus.m_ready = rdy;
    if (acc[0]) exp_q0.push_back(d);
    if (acc[1]) exp_q1.push_back(d);
    @(posedge clk);
    #1;
    bus.out_en  = '0;
    bus.m_ready = '0;
  endtask

  task automatic drain(input int k, input int max, output int n);
    logic [1:0] rdy;
    rdy = 2'b01 << k;
    n = 0;
    while (bus.m_valid[k] && n < max) begin
      cyc(2'b00, 32'd0, rdy, 2'b00);
      n++;
    end
    chk($sformatf("ch%0d_drain_done", k), 64'(bus.m_valid[k]), 64'd0);
  endtask

  initial begin
    int n;
    bus.io_out  = '0;
    bus.out_en  = '0;
    bus.m_ready = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset_valid", 64'(bus.m_valid), 64'd0);
    chk("reset_level", 64'(bus.level), 64'd0);
    chk("reset_full", 64'(bus.full), 64'd0);
    chk("reset_ovf", 64'(bus.ovf), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // single write of -10 into channel 0
    cyc(2'b01, 32'hFFFF_FFF6, 2'b00, 2'b01);
    chk("single_valid", 64'(bus.m_valid), 64'h1);
    chk("single_data0", 64'(bus.m_data[31:0]), 64'hFFFF_FFF6);
    chk("single_data1", 64'(bus.m_data[63:32]), 64'h0);
    chk("single_level0", 64'(lvl(0)), 64'd1);
    chk("single_level1", 64'(lvl(1)), 64'd0);
    cyc(2'b00, 32'd0, 2'b01, 2'b00);
    chk("single_after_pop", 64'(bus.m_valid), 64'd0);

    // reset with three words buffered in channel 0
    cyc(2'b01, 32'h11, 2'b00, 2'b01);
    cyc(2'b01, 32'h22, 2'b00, 2'b01);
    cyc(2'b01, 32'h33, 2'b00, 2'b01);
    chk("pre_reset_level0", 64'(lvl(0)), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.m_valid), 64'd0);
    chk("midrst_level", 64'(bus.level), 64'd0);
    chk("midrst_data", 64'(bus.m_data), 64'd0);
    chk("midrst_full_ovf", 64'({bus.full, bus.ovf}), 64'd0);
    exp_q0.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_level", 64'(bus.level), 64'd0);
    chk("postrst_valid", 64'(bus.m_valid), 64'd0);

    // ordering across wrap on channel 1, popping every other cycle
    for (int i = 1; i <= 12; i++)
      cyc(2'b10, 32'(i), (i % 2 == 0) ? 2'b10 : 2'b00, 2'b10);
    chk("wrap_level1", 64'(lvl(1)), 64'd6);
    drain(1, 20, n);
    chk("wrap_drained", 64'(n), 64'd6);
    chk("wrap_ovf1", 64'(bus.ovf[1]), 64'd0);

    // full channel with simultaneous push and pop
    for (int i = 0; i < 8; i++) cyc(2'b01, 32'(100 + i), 2'b00, 2'b01);
    chk("fp_full", 64'(bus.full[0]), 64'd1);
    chk("fp_level", 64'(lvl(0)), 64'd8);
    cyc(2'b01, 32'd108, 2'b01, 2'b01);
    chk("fp_level_kept", 64'(lvl(0)), 64'd8);
    chk("fp_ovf", 64'(bus.ovf[0]), 64'd0);
    chk("fp_full_kept", 64'(bus.full[0]), 64'd1);
    drain(0, 20, n);
    chk("fp_drained", 64'(n), 64'd8);

    // overflow: ninth word dropped
    for (int i = 1; i <= 9; i++) begin
      cyc(2'b01, 32'(i), 2'b00, (i <= 8) ? 2'b01 : 2'b00);
      if (i == 8) begin
        chk("ovf_full_at8", 64'(bus.full[0]), 64'd1);
        chk("ovf_clear_at8", 64'(bus.ovf[0]), 64'd0);
      end
    end
    chk("ovf_set", 64'(bus.ovf[0]), 64'd1);
    chk("ovf_level", 64'(lvl(0)), 64'd8);
    drain(0, 20, n);
    chk("ovf_drained", 64'(n), 64'd8);
    chk("ovf_sticky", 64'(bus.ovf[0]), 64'd1);

    // concurrent channels: ch0 popping at full rate, ch1 stalled
    for (int i = 0; i < 4; i++) begin
      cyc(2'b01, 32'(32'hA0 + i), 2'b01, 2'b01);
      cyc(2'b10, 32'(32'hB0 + i), 2'b01, 2'b10);
    end
    chk("conc_level0", 64'(lvl(0)), 64'd0);
    chk("conc_level1", 64'(lvl(1)), 64'd4);
    chk("conc_valid", 64'(bus.m_valid), 64'h2);
    chk("conc_head1", 64'(bus.m_data[63:32]), 64'hB0);
    chk("conc_data0_zero", 64'(bus.m_data[31:0]), 64'h0);

    // both strobes high: each channel takes the same word
    cyc(2'b11, 32'h55, 2'b00, 2'b11);
    chk("multi_level0", 64'(lvl(0)), 64'd1);
    chk("multi_level1", 64'(lvl(1)), 64'd5);
    drain(0, 20, n);
    drain(1, 20, n);
    chk("multi_drained1", 64'(n), 64'd5);

    chk("sb_empty0", 64'(exp_q0.size()), 64'd0);
    chk("sb_empty1", 64'(exp_q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
